// File: rtl/i2s_audio_tx.sv
// I2S transmitter: fractional-NCO bit clock, 64 BCK per frame, one stereo pair latched per frame.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing; default is standard Philips I2S.
module i2s_audio_tx #(
  parameter int CLK_RATE   = 32000000,
  parameter int AUDIO_RATE = 48000,
  parameter int AUDIO_DW   = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [AUDIO_DW-1:0] left_in,
  input  logic [AUDIO_DW-1:0] right_in,
  input  logic                mute,
  output logic                sample_strobe,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int            AW      = $clog2(CLK_RATE) + 1;
  localparam logic [AW-1:0] STEP    = AW'(128 * AUDIO_RATE);
  localparam logic [AW-1:0] MODULUS = AW'(CLK_RATE);

  logic [AW-1:0]       r_acc;
  logic                r_bck;
  logic                r_lrck;
  logic                r_data;
  logic                r_strobe;
  logic [5:0]          r_bit_cnt;
  logic [AUDIO_DW-1:0] r_left;
  logic [AUDIO_DW-1:0] r_right;

  logic [AW-1:0]       w_sum;
  logic [AW-1:0]       w_acc_next;
  logic                w_tick;
  logic                w_fall;
  logic                w_frame_start;
  logic [5:0]          w_cnt_next;
  logic [AUDIO_DW-1:0] w_left_next;
  logic [AUDIO_DW-1:0] w_right_next;
  logic [AUDIO_DW-1:0] w_word;
  logic                w_bit;

  // Serial bit for a slot; w_pos is the 1-based MSB-first bit position carried by that slot.
  function automatic logic slot_bit(input logic [AUDIO_DW-1:0] word, input logic [4:0] slot);
    logic [5:0]          w_pos;
    logic [AUDIO_DW-1:0] w_sh;
    logic                w_out;
`ifdef I2S_LEFT_JUSTIFIED_EN
    w_pos = {1'b0, slot} + 6'd1;
`else
    w_pos = {1'b0, slot};
`endif
    w_sh = word << (w_pos - 6'd1);
    if ((w_pos != 6'd0) && (w_pos <= 6'(AUDIO_DW))) begin
      w_out = w_sh[AUDIO_DW-1];
    end else begin
      w_out = 1'b0;
    end
    return w_out;
  endfunction

  always_comb begin
    w_sum = r_acc + STEP;
    w_tick = (w_sum >= MODULUS);
    if (w_tick) begin
      w_acc_next = w_sum - MODULUS;
    end else begin
      w_acc_next = w_sum;
    end
    w_fall        = w_tick & r_bck;
    w_cnt_next    = r_bit_cnt + 6'd1;
    w_frame_start = w_fall && (r_bit_cnt == 6'd63);
    // The new pair must already feed the slot-0 bit in the frame-start cycle.
    if (w_frame_start) begin
      if (mute) begin
        w_left_next  = '0;
        w_right_next = '0;
      end else begin
        w_left_next  = left_in;
        w_right_next = right_in;
      end
    end else begin
      w_left_next  = r_left;
      w_right_next = r_right;
    end
    if (w_cnt_next[5]) begin
      w_word = w_right_next;
    end else begin
      w_word = w_left_next;
    end
    w_bit = slot_bit(w_word, w_cnt_next[4:0]);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_bck     <= 1'b0;
      r_lrck    <= 1'b0;
      r_data    <= 1'b0;
      r_strobe  <= 1'b0;
      r_bit_cnt <= 6'd63;
      r_left    <= '0;
      r_right   <= '0;
    end else begin
      r_acc    <= w_acc_next;
      r_strobe <= w_frame_start;
      if (w_tick) begin
        r_bck <= ~r_bck;
      end else begin
        r_bck <= r_bck;
      end
      // Everything the DAC sees moves only on the falling half of BCK.
      if (w_fall) begin
        r_bit_cnt <= w_cnt_next;
        r_lrck    <= w_cnt_next[5];
        r_data    <= w_bit;
        r_left    <= w_left_next;
        r_right   <= w_right_next;
      end else begin
        r_bit_cnt <= r_bit_cnt;
        r_lrck    <= r_lrck;
        r_data    <= r_data;
        r_left    <= r_left;
        r_right   <= r_right;
      end
    end
  end

  assign sample_strobe = r_strobe;
  assign i2s_bck       = r_bck;
  assign i2s_lrck      = r_lrck;
  assign i2s_data      = r_data;

endmodule
